// File: rtl/afifo_pkg.sv
// Shared types and width helpers for the async FIFO read/write schedulers.
package afifo_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int grant_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int count_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit after the last winner.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int GW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last,
  output logic [GW-1:0]   winner,
  output logic            any_req
);

  logic          found;
  logic [GW-1:0] idx;

  // Scan starts one past the last winner, so the previous grantee is considered last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = GW'((int'(last) + k) % NREQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Write-side scheduler: shares one async-FIFO write port among NREQ requesters
// with round-robin burst grants, honouring wr_full without dropping words.
module afifo_wr_arbiter
  import afifo_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4,
  localparam int GW       = grant_width(NREQ),
  localparam int CW       = count_width(MAX_BURST)
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wr_full,
  output logic                  wr_inc,
  output logic [DSIZE-1:0]      wr_data,
  output logic [GW-1:0]         grant_id,
  output logic                  busy
);

  // Handshake: a word moves on a wr_clk edge where req_valid[i] & req_ready[i];
  // the requester holds req_data stable until then, and ready never depends
  // on anything but the registered grant, that requester's valid and wr_full.

  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [CW-1:0] count_q, count_d;

  logic [GW-1:0] winner;
  logic          any_req;
  logic          granted_valid;

  rr_picker #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_picker (
    .req     (req_valid),
    .last    (rr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  assign granted_valid = req_valid[grant_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        // wr_full is ignored here on purpose: the grant is taken and the burst stalls.
        if (any_req) begin
          grant_d = winner;
          rr_d    = winner;
          count_d = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (!granted_valid) begin
          state_d = IDLE;
          count_d = '0;
        end else if (!wr_full) begin
          if (count_q == LAST_CNT) begin
            state_d = IDLE;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= GW'(NREQ - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      count_q <= count_d;
    end
  end

  assign busy      = (state_q == BURST);
  assign grant_id  = grant_q;
  assign wr_inc    = busy & granted_valid & ~wr_full;
  assign req_ready = wr_inc ? (NREQ'(1) << grant_q) : '0;
  assign wr_data   = busy ? req_data[grant_q*DSIZE +: DSIZE] : '0;

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Scoreboard bench for afifo_wr_arbiter: a 4-requester/4-burst instance and a
// 2-requester/single-word instance, with directed word lists per requester.
module tb_afifo_wr_arbiter;

  localparam int DSIZE = 8;
  localparam int NREQ  = 4;
  localparam int GW    = 2;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic wr_clk = 1'b0;
  logic wr_rst = 1'b1;
  always #5 wr_clk = ~wr_clk;

  // ---------------- DUT 1: NREQ=4, MAX_BURST=4 ----------------
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wr_full;
  logic                  wr_inc;
  logic [DSIZE-1:0]      wr_data;
  logic [GW-1:0]         grant_id;
  logic                  busy;

  afifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(4)) dut (
    .wr_clk    (wr_clk),
    .wr_rst    (wr_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_full   (wr_full),
    .wr_inc    (wr_inc),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // ---------------- DUT 2: NREQ=2, MAX_BURST=1 ----------------
  logic [1:0]       req_valid2;
  logic [2*DSIZE-1:0] req_data2;
  logic [1:0]       req_ready2;
  logic             wr_full2;
  logic             wr_inc2;
  logic [DSIZE-1:0] wr_data2;
  logic [0:0]       grant_id2;
  logic             busy2;

  afifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(2), .MAX_BURST(1)) dut2 (
    .wr_clk    (wr_clk),
    .wr_rst    (wr_rst),
    .req_valid (req_valid2),
    .req_data  (req_data2),
    .req_ready (req_ready2),
    .wr_full   (wr_full2),
    .wr_inc    (wr_inc2),
    .wr_data   (wr_data2),
    .grant_id  (grant_id2),
    .busy      (busy2)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [GW+DSIZE-1:0] exp_q[$];
  logic [1+DSIZE-1:0]  exp2_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h", name, act, req);
    end
  endtask

  // ---------------- requester models ----------------
  logic [DSIZE-1:0] src_mem [NREQ][DEPTH];
  int               src_head [NREQ];
  int               src_len  [NREQ];
  logic [NREQ-1:0]  ready_cap;

  int               rem2 [2];
  int               seq2 [2];
  logic [1:0]       ready2_cap;

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (src_head[i] < src_len[i]);
      req_data[i*DSIZE +: DSIZE] = req_valid[i] ? src_mem[i][src_head[i]] : '0;
    end
    for (int i = 0; i < 2; i++) begin
      req_valid2[i] = (rem2[i] > 0);
      req_data2[i*DSIZE +: DSIZE] = {4'(i), 4'(seq2[i])};
    end
  endtask

  task automatic load(input int id, input logic [DSIZE-1:0] d);
    src_mem[id][src_len[id]] = d;
    src_len[id]++;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NREQ; i++) begin
      src_head[i] = 0;
      src_len[i]  = 0;
    end
    for (int i = 0; i < 2; i++) begin
      rem2[i] = 0;
      seq2[i] = 0;
    end
    drive_inputs();
  endtask

  // Capture handshakes mid-cycle; retire accepted words just after the edge.
  always @(negedge wr_clk) begin
    ready_cap  <= req_ready;
    ready2_cap <= req_ready2;
  end

  initial begin
    forever begin
      @(posedge wr_clk);
      #1;
      for (int i = 0; i < NREQ; i++)
        if (ready_cap[i]) src_head[i]++;
      for (int i = 0; i < 2; i++)
        if (ready2_cap[i]) begin
          rem2[i]--;
          seq2[i]++;
        end
      drive_inputs();
    end
  end

  // ---------------- monitors ----------------
  always @(negedge wr_clk) begin
    if (!wr_rst) begin
      checks++;
      if (req_ready !== (wr_inc ? (NREQ'(1) << grant_id) : NREQ'(0))) begin
        errors++;
        $display("FAIL ready_onehot: actual %b, required grant %0d inc %b", req_ready, grant_id, wr_inc);
      end
      if (wr_inc) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: actual grant %0d data %h, required no write", grant_id, wr_data);
        end else begin
          logic [GW+DSIZE-1:0] e;
          e = exp_q.pop_front();
          if ({grant_id, wr_data} !== e) begin
            errors++;
            $display("FAIL write_order: actual grant %0d data %h, required grant %0d data %h",
                     grant_id, wr_data, e[GW+DSIZE-1:DSIZE], e[DSIZE-1:0]);
          end
        end
      end
    end
  end

  always @(negedge wr_clk) begin
    if (!wr_rst) begin
      checks++;
      if (req_ready2 !== (wr_inc2 ? (2'b01 << grant_id2) : 2'b00)) begin
        errors++;
        $display("FAIL ready2_onehot: actual %b, required grant %0d inc %b", req_ready2, grant_id2, wr_inc2);
      end
      if (wr_inc2) begin
        checks++;
        if (exp2_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write2: actual grant %0d data %h, required no write", grant_id2, wr_data2);
        end else begin
          logic [DSIZE:0] e;
          e = exp2_q.pop_front();
          if ({grant_id2, wr_data2} !== e) begin
            errors++;
            $display("FAIL write_order2: actual grant %0d data %h, required grant %0d data %h",
                     grant_id2, wr_data2, e[DSIZE], e[DSIZE-1:0]);
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    wr_rst   = 1'b1;
    wr_full  = 1'b0;
    wr_full2 = 1'b0;
    clear_sources();
    repeat (2) @(negedge wr_clk);
    #2 wr_rst = 1'b0;
    @(posedge wr_clk);
    #2;
  endtask

  // Wait until the expected queue empties, returning the negedges taken, then for idle.
  task automatic drain(input int which, output int cycles);
    int n;
    int left;
    n = 0;
    left = (which == 0) ? exp_q.size() : exp2_q.size();
    while (left != 0 && n < 200) begin
      @(negedge wr_clk);
      #1;
      n++;
      left = (which == 0) ? exp_q.size() : exp2_q.size();
    end
    cycles = n;
    check($sformatf("drain_words_%0d", which), left, 0);
    n = 0;
    while (((which == 0) ? busy : busy2) && n < 50) begin
      @(negedge wr_clk);
      #1;
      n++;
    end
    check($sformatf("drain_idle_%0d", which), (which == 0) ? busy : busy2, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    int cyc;
    wr_full  = 1'b0;
    wr_full2 = 1'b0;
    clear_sources();
    #1;
    check("rst_busy",    busy,      0);
    check("rst_wr_inc",  wr_inc,    0);
    check("rst_ready",   req_ready, 0);
    check("rst_wr_data", wr_data,   0);
    check("rst_grant",   grant_id,  0);

    // Single requester, one full burst.
    do_reset();
    for (int s = 0; s < 4; s++) begin
      load(0, 8'hA1 + 8'(s));
      exp_q.push_back({2'd0, 8'hA1 + 8'(s)});
    end
    drive_inputs();
    @(negedge wr_clk);
    #1;
    check("t1_arb_cycle_busy", busy, 0);
    drain(0, cyc);
    check("t1_burst_cycles", cyc, 4);

    // All four continuously valid: rotation 0,1,2,3,0 with one bubble per burst.
    do_reset();
    for (int i = 0; i < NREQ; i++)
      for (int s = 0; s < ((i == 0) ? 8 : 4); s++)
        load(i, {4'(i), 4'(s)});
    for (int r = 0; r < 5; r++)
      for (int s = 0; s < 4; s++)
        exp_q.push_back({2'(r % 4), 4'(r % 4), 4'((r == 4) ? s + 4 : s)});
    drive_inputs();
    drain(0, cyc);
    check("t2_rotation_cycles", cyc, 25);

    // Backpressure freeze after two words of req1.
    do_reset();
    for (int s = 0; s < 4; s++) begin
      load(1, 8'hB1 + 8'(s));
      exp_q.push_back({2'd1, 8'hB1 + 8'(s)});
    end
    drive_inputs();
    repeat (3) @(posedge wr_clk);
    #2 wr_full = 1'b1;
    check("t3_words_before_full", exp_q.size(), 2);
    for (int c = 0; c < 5; c++) begin
      @(negedge wr_clk);
      #1;
      check($sformatf("t3_stall%0d_inc", c),   wr_inc,    0);
      check($sformatf("t3_stall%0d_ready", c), req_ready, 0);
      check($sformatf("t3_stall%0d_busy", c),  busy,      1);
      check($sformatf("t3_stall%0d_grant", c), grant_id,  1);
    end
    @(posedge wr_clk);
    #2 wr_full = 1'b0;
    drain(0, cyc);
    check("t3_resume_cycles", cyc, 2);

    // req2 releases after one word; req3 is next in rotation ahead of req0.
    do_reset();
    load(2, 8'hC1);
    exp_q.push_back({2'd2, 8'hC1});
    drive_inputs();
    @(posedge wr_clk);
    #2;
    load(3, 8'hE1);
    load(3, 8'hE2);
    load(0, 8'hD1);
    load(0, 8'hD2);
    exp_q.push_back({2'd3, 8'hE1});
    exp_q.push_back({2'd3, 8'hE2});
    exp_q.push_back({2'd0, 8'hD1});
    exp_q.push_back({2'd0, 8'hD2});
    drive_inputs();
    @(negedge wr_clk);
    @(negedge wr_clk);
    #1;
    check("t4_released_busy", busy,   1);
    check("t4_released_inc",  wr_inc, 0);
    @(negedge wr_clk);
    #1;
    check("t4_back_to_idle",  busy,   0);
    drain(0, cyc);

    // Asynchronous reset between edges in the middle of a burst.
    do_reset();
    for (int s = 0; s < 4; s++) load(0, 8'hF1 + 8'(s));
    exp_q.push_back({2'd0, 8'hF1});
    exp_q.push_back({2'd0, 8'hF2});
    drive_inputs();
    repeat (3) @(posedge wr_clk);
    #3;
    check("t5_pre_reset_inc", wr_inc, 1);
    wr_rst = 1'b1;
    #1;
    check("t5_async_inc",   wr_inc,    0);
    check("t5_async_ready", req_ready, 0);
    check("t5_async_busy",  busy,      0);
    check("t5_async_grant", grant_id,  0);
    check("t5_words_before_reset", exp_q.size(), 0);
    clear_sources();
    load(1, 8'h71);
    load(0, 8'h70);
    exp_q.push_back({2'd0, 8'h70});
    exp_q.push_back({2'd1, 8'h71});
    drive_inputs();
    @(negedge wr_clk);
    #2 wr_rst = 1'b0;
    drain(0, cyc);

    // NREQ=2, MAX_BURST=1: single-word alternation with an idle cycle between.
    do_reset();
    rem2[0] = 2;
    rem2[1] = 2;
    exp2_q.push_back({1'b0, 8'h00});
    exp2_q.push_back({1'b1, 8'h10});
    exp2_q.push_back({1'b0, 8'h01});
    exp2_q.push_back({1'b1, 8'h11});
    drive_inputs();
    drain(1, cyc);
    check("t6_alternate_cycles", cyc, 8);

    repeat (2) @(negedge wr_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
